// File: rtl/uart_tx_fifo_ctrl_if.sv
// uart_tx_fifo_ctrl_if: byte FIFO handshake bundle between the bus-side writer/transmitter (master) and the FIFO (slave)
//   wr_en/wdata        byte enqueue strobe and data
//   fifo_read_n        active-low dequeue strobe from the transmitter
//   flush/ovf_clr      synchronous clear of contents / sticky overflow clear
//   rdata              registered head byte
//   fifo_empty/full    registered occupancy flags
//   fifo_level         registered occupancy, 0..DEPTH
//   overflow           sticky dropped-write flag
interface uart_tx_fifo_ctrl_if #(parameter int ADDR_WIDTH = 4);
  logic                  wr_en;
  logic [7:0]            wdata;
  logic                  fifo_read_n;
  logic                  flush;
  logic                  ovf_clr;
  logic [7:0]            rdata;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [ADDR_WIDTH:0]   fifo_level;
  logic                  overflow;
  modport master (
    output wr_en, wdata, fifo_read_n, flush, ovf_clr,
    input  rdata, fifo_empty, fifo_full, fifo_level, overflow
  );
  modport slave (
    input  wr_en, wdata, fifo_read_n, flush, ovf_clr,
    output rdata, fifo_empty, fifo_full, fifo_level, overflow
  );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: synchronous byte FIFO between the TX-data register write and the UART transmitter
//   clk      system clock, rising edge
//   reset_n  asynchronous reset, active low
//   bus      uart_tx_fifo_ctrl_if.slave (wr_en, wdata, fifo_read_n, flush, ovf_clr in; rdata, flags, level, overflow out)
//   ADDR_WIDTH sets DEPTH = 1<<ADDR_WIDTH bytes (1..8)
//   Define UART_TX_FIFO_OVF_EN to build the sticky overflow flag; otherwise overflow is tied low and ovf_clr ignored
module uart_tx_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input logic clk,
  input logic reset_n,
  uart_tx_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] full_lvl = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   level, level_nxt;
  logic [7:0]            rdata;
  logic                  empty, full;
  logic                  rd_acc, wr_acc, rd_go, wr_go;
  always_comb begin
    rd_acc    = !bus.fifo_read_n && !empty;
    wr_acc    = bus.wr_en && (!full || rd_acc);
    rd_go     = rd_acc && !bus.flush;
    wr_go     = wr_acc && !bus.flush;
    level_nxt = bus.flush ? '0 : level + {{ADDR_WIDTH{1'b0}}, wr_go} - {{ADDR_WIDTH{1'b0}}, rd_go};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdata  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= bus.flush ? '0 : wr_ptr + ADDR_WIDTH'(wr_go);
      rd_ptr <= bus.flush ? '0 : rd_ptr + ADDR_WIDTH'(rd_go);
      rdata  <= rd_go ? mem[rd_ptr] : rdata;
      level  <= level_nxt;
      empty  <= level_nxt == '0;
      full   <= level_nxt == full_lvl;
    end
  always_ff @(posedge clk)
    if (wr_go) mem[wr_ptr] <= bus.wdata;
`ifdef UART_TX_FIFO_OVF_EN
  logic ovf;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovf <= 1'b0;
    else ovf <= (bus.wr_en && full && !rd_acc) ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf;
  assign bus.overflow = ovf;
`else
  assign bus.overflow = 1'b0;
`endif
  assign bus.rdata      = rdata;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl: directed scenarios plus randomized traffic checked against a queue-based FIFO model
module tb_uart_tx_fifo_ctrl;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  logic [7:0] rdata_m = 8'h00;
  logic ovf_m = 1'b0;
  uart_tx_fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus();
  uart_tx_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc();
    bit rd_raw, wr;
    rd_raw = !bus.fifo_read_n && q.size() > 0;
`ifdef UART_TX_FIFO_OVF_EN
    if (bus.wr_en && q.size() == DEPTH && !rd_raw) ovf_m = 1'b1;
    else if (bus.ovf_clr) ovf_m = 1'b0;
`endif
    if (bus.flush) q.delete();
    else begin
      wr = bus.wr_en && (q.size() < DEPTH || rd_raw);
      if (rd_raw) rdata_m = q.pop_front();
      if (wr) q.push_back(bus.wdata);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] b);
    bus.wr_en = 1'b1;
    bus.wdata = b;
    cyc();
    bus.wr_en = 1'b0;
  endtask
  task automatic rd();
    bus.fifo_read_n = 1'b0;
    cyc();
    bus.fifo_read_n = 1'b1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();
    vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", bus.fifo_empty); end
    vectors++; if (bus.fifo_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", bus.fifo_full); end
    vectors++; if (bus.fifo_level !== 5'd0) begin miscompares++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
  endtask
  task automatic test_basic();
    wr(8'hA5);
    wr(8'h3C);
    rd();
    vectors++; if (bus.rdata !== 8'hA5) begin miscompares++; $display("FAIL basic_rd0 got=%h exp=a5", bus.rdata); end
    vectors++; if (bus.fifo_level !== 5'd1) begin miscompares++; $display("FAIL basic_level got=%0d exp=1", bus.fifo_level); end
    rd();
    vectors++; if (bus.rdata !== 8'h3C) begin miscompares++; $display("FAIL basic_rd1 got=%h exp=3c", bus.rdata); end
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty got=%b exp=1", bus.fifo_empty); end
  endtask
  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    vectors++; if (bus.fifo_full !== 1'b1) begin miscompares++; $display("FAIL full_flag got=%b exp=1", bus.fifo_full); end
    vectors++; if (bus.fifo_level !== 5'd16) begin miscompares++; $display("FAIL full_level got=%0d exp=16", bus.fifo_level); end
    wr(8'hFF);
    vectors++; if (bus.fifo_level !== 5'd16) begin miscompares++; $display("FAIL full_drop_level got=%0d exp=16", bus.fifo_level); end
    for (int i = 0; i < DEPTH; i++) begin
      rd();
      vectors++; if (bus.rdata !== 8'(i)) begin miscompares++; $display("FAIL full_drain%0d got=%h exp=%h", i, bus.rdata, 8'(i)); end
    end
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL full_drain_empty got=%b exp=1", bus.fifo_empty); end
  endtask
  task automatic test_full_rw();
    logic [7:0] arr [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      arr[i] = 8'($urandom);
      wr(arr[i]);
    end
    bus.wr_en = 1'b1;
    bus.wdata = 8'h77;
    bus.fifo_read_n = 1'b0;
    cyc();
    bus.wr_en = 1'b0;
    bus.fifo_read_n = 1'b1;
    vectors++; if (bus.rdata !== arr[0]) begin miscompares++; $display("FAIL fullrw_rdata got=%h exp=%h", bus.rdata, arr[0]); end
    vectors++; if (bus.fifo_level !== 5'd16) begin miscompares++; $display("FAIL fullrw_level got=%0d exp=16", bus.fifo_level); end
    vectors++; if (bus.fifo_full !== 1'b1) begin miscompares++; $display("FAIL fullrw_full got=%b exp=1", bus.fifo_full); end
    for (int i = 1; i < DEPTH; i++) begin
      rd();
      vectors++; if (bus.rdata !== arr[i]) begin miscompares++; $display("FAIL fullrw_drain%0d got=%h exp=%h", i, bus.rdata, arr[i]); end
    end
    rd();
    vectors++; if (bus.rdata !== 8'h77) begin miscompares++; $display("FAIL fullrw_last got=%h exp=77", bus.rdata); end
  endtask
  task automatic test_empty_rw();
    bus.wr_en = 1'b1;
    bus.wdata = 8'h11;
    bus.fifo_read_n = 1'b0;
    cyc();
    bus.wr_en = 1'b0;
    bus.fifo_read_n = 1'b1;
    vectors++; if (bus.rdata !== 8'h77) begin miscompares++; $display("FAIL emptyrw_rdata got=%h exp=77", bus.rdata); end
    vectors++; if (bus.fifo_level !== 5'd1) begin miscompares++; $display("FAIL emptyrw_level got=%0d exp=1", bus.fifo_level); end
    rd();
    vectors++; if (bus.rdata !== 8'h11) begin miscompares++; $display("FAIL emptyrw_next got=%h exp=11", bus.rdata); end
    rd();
    vectors++; if (bus.rdata !== 8'h11) begin miscompares++; $display("FAIL empty_read_hold got=%h exp=11", bus.rdata); end
    vectors++; if (bus.fifo_level !== 5'd0) begin miscompares++; $display("FAIL empty_read_level got=%0d exp=0", bus.fifo_level); end
  endtask
  task automatic test_flush();
    for (int i = 0; i < 5; i++) wr(8'(8'h50 + i));
    vectors++; if (bus.fifo_level !== 5'd5) begin miscompares++; $display("FAIL flush_pre_level got=%0d exp=5", bus.fifo_level); end
    bus.flush = 1'b1;
    bus.wr_en = 1'b1;
    bus.wdata = 8'hEE;
    cyc();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    vectors++; if (bus.fifo_level !== 5'd0) begin miscompares++; $display("FAIL flush_level got=%0d exp=0", bus.fifo_level); end
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL flush_empty got=%b exp=1", bus.fifo_empty); end
    vectors++; if (bus.rdata !== 8'h11) begin miscompares++; $display("FAIL flush_rdata got=%h exp=11", bus.rdata); end
    wr(8'h42);
    rd();
    vectors++; if (bus.rdata !== 8'h42) begin miscompares++; $display("FAIL flush_after got=%h exp=42", bus.rdata); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] exp;
    wr(8'hC1);
    wr(8'hC2);
    wr(8'hC3);
    bus.fifo_read_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp = (i < 3) ? 8'(8'hC1 + i) : 8'hC3;
      vectors++; if (bus.rdata !== exp) begin miscompares++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, bus.rdata, exp); end
    end
    bus.fifo_read_n = 1'b1;
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty got=%b exp=1", bus.fifo_empty); end
  endtask
  task automatic test_overflow();
    logic exp_ovf;
`ifdef UART_TX_FIFO_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_before got=%b exp=0", bus.overflow); end
    wr(8'hAB);
    vectors++; if (bus.overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_set got=%b exp=%b", bus.overflow, exp_ovf); end
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got=%b exp=0", bus.overflow); end
    bus.ovf_clr = 1'b1;
    wr(8'hAC);
    bus.ovf_clr = 1'b0;
    vectors++; if (bus.overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_set_wins got=%b exp=%b", bus.overflow, exp_ovf); end
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    vectors++; if (bus.overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_flush_keep got=%b exp=%b", bus.overflow, exp_ovf); end
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
  endtask
  task automatic test_random();
    int wr_pct;
    for (int n = 0; n < 3000; n++) begin
      wr_pct = (n / 300) % 2 ? 30 : 75;
      bus.wr_en = ($urandom_range(99) < wr_pct);
      bus.wdata = 8'($urandom);
      bus.fifo_read_n = ($urandom_range(99) < wr_pct);
      bus.flush = ($urandom_range(63) == 0);
      bus.ovf_clr = ($urandom_range(7) == 0);
      cyc();
      vectors++; if (bus.rdata !== rdata_m) begin miscompares++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, bus.rdata, rdata_m); end
      vectors++; if (bus.fifo_level !== 5'(q.size())) begin miscompares++; $display("FAIL rnd%0d_level got=%0d exp=%0d", n, bus.fifo_level, q.size()); end
      vectors++; if (bus.fifo_empty !== (q.size() == 0)) begin miscompares++; $display("FAIL rnd%0d_empty got=%b exp=%b", n, bus.fifo_empty, q.size() == 0); end
      vectors++; if (bus.fifo_full !== (q.size() == DEPTH)) begin miscompares++; $display("FAIL rnd%0d_full got=%b exp=%b", n, bus.fifo_full, q.size() == DEPTH); end
      vectors++; if (bus.overflow !== ovf_m) begin miscompares++; $display("FAIL rnd%0d_ovf got=%b exp=%b", n, bus.overflow, ovf_m); end
    end
    bus.wr_en = 1'b0;
    bus.fifo_read_n = 1'b1;
    bus.flush = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask
  task automatic test_reset_mid();
    wr(8'h91);
    wr(8'h92);
    rd();
    bus.wr_en = 1'b1;
    bus.wdata = 8'h93;
    #2;
    reset_n = 1'b0;
    #1;
    vectors++; if (bus.fifo_level !== 5'd0) begin miscompares++; $display("FAIL rstmid_level got=%0d exp=0", bus.fifo_level); end
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL rstmid_empty got=%b exp=1", bus.fifo_empty); end
    vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("FAIL rstmid_rdata got=%h exp=00", bus.rdata); end
    bus.wr_en = 1'b0;
    q.delete();
    rdata_m = 8'h00;
    ovf_m = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #3;
    rd();
    vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("FAIL rstmid_lost got=%h exp=00", bus.rdata); end
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wdata = 8'h00;
    bus.fifo_read_n = 1'b1;
    bus.flush = 1'b0;
    bus.ovf_clr = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_full_rw();
    test_empty_rw();
    test_flush();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
